// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared mode constants and channel-index helper for mux_nto1_rr
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Wrap-around add of two channel offsets; both operands are expected below n.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter starting its scan at ptr
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx,
  output logic          grant_any
);

  // Scan ptr, ptr+1, ... modulo N and grant the first requester found.
  always_comb begin
    int k;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    k         = 0;
    for (int i = 0; i < N; i++) begin
      k = wrap_add(int'(ptr), i, N);
      if (enable && !grant_any && req[SW'(k)]) begin
        grant[SW'(k)] = 1'b1;
        grant_idx     = SW'(k);
        grant_any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_rr.sv
// rtl/mux_nto1_rr.sv - N:1 stream mux with fixed-select or round-robin arbitration
module mux_nto1_rr
  import mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  data_in,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic [SW-1:0]   sel_n,
  input  logic            mode,
  output logic [W-1:0]    data_out,
  output logic [SW-1:0]   out_ch,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [SW-1:0] rr_ptr;
  logic [N-1:0]  rr_grant;
  logic [SW-1:0] rr_idx;
  logic          rr_any;

  logic          fixed_any;
  logic          win_any;
  logic [SW-1:0] win_idx;
  logic [W-1:0]  win_data;
  logic          load;

  rr_arbiter #(.N(N)) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .enable    (mode == MODE_RR),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .grant_any (rr_any)
  );

  // The output register accepts a new word whenever it is empty or being drained.
  assign load = !out_valid || out_ready;

  // Pick the winner for the current mode; out-of-range selects never grant.
  always_comb begin
    fixed_any = 1'b0;
    if ({1'b0, sel_n} < (SW + 1)'(N)) begin
      fixed_any = in_valid[sel_n];
    end
    if (mode == MODE_RR) begin
      win_any = rr_any;
      win_idx = rr_idx;
    end else begin
      win_any = fixed_any;
      win_idx = sel_n;
    end
  end

  // Route the winning channel's data and raise exactly one ready bit.
  always_comb begin
    win_data = '0;
    in_ready = '0;
    for (int k = 0; k < N; k++) begin
      if (win_idx == SW'(k)) begin
        win_data = data_in[k*W +: W];
      end
    end
    if (load && win_any && !rst) begin
      in_ready[win_idx] = 1'b1;
    end
  end

  // Output register and round-robin pointer; fixed-mode grants leave the pointer alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (win_any) begin
        data_out  <= win_data;
        out_ch    <= win_idx;
        out_valid <= 1'b1;
        if (mode == MODE_RR) begin
          rr_ptr <= SW'(wrap_add(int'(win_idx), 1, N));
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nto1_rr.sv
// tb/tb_mux_nto1_rr.sv - directed vector bench for mux_nto1_rr
module tb_mux_nto1_rr;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [1:0]     sel_n;
  logic           mode;
  logic [W-1:0]   data_out;
  logic [1:0]     out_ch;
  logic           out_valid;
  logic           out_ready;

  int total;
  int bad;

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic       oready;
    logic [3:0] ir;
    logic       ov;
    logic [7:0] dat;
    logic [1:0] ch;
  } vec_t;

  vec_t tbl[$];

  mux_nto1_rr #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel_n     (sel_n),
    .mode      (mode),
    .data_out  (data_out),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic m, input logic [1:0] s, input logic [3:0] v, input logic o,
                     input logic [3:0] ir, input logic ov, input logic [7:0] d, input logic [1:0] c);
    vec_t e;
    e.mode = m; e.sel = s; e.valid = v; e.oready = o;
    e.ir = ir; e.ov = ov; e.dat = d; e.ch = c;
    tbl.push_back(e);
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [7:0] d, input logic [1:0] c);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".data_out"},  32'(data_out),  32'(d));
    chk({tag, ".out_ch"},    32'(out_ch),    32'(c));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    data_in   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    rst       = 1'b1;
    in_valid  = 4'b1111;
    sel_n     = 2'd0;
    mode      = 1'b1;
    out_ready = 1'b1;

    // fixed sweep
    add(0, 0, 4'hF, 1, 4'b0001, 1, 8'hA0, 0);
    add(0, 1, 4'hF, 1, 4'b0010, 1, 8'hA1, 1);
    add(0, 2, 4'hF, 1, 4'b0100, 1, 8'hA2, 2);
    add(0, 3, 4'hF, 1, 4'b1000, 1, 8'hA3, 3);
    // fixed select on an idle channel
    add(0, 2, 4'b1011, 1, 4'b0000, 0, 8'hA3, 3);
    add(0, 2, 4'b1011, 1, 4'b0000, 0, 8'hA3, 3);
    // round-robin fairness, pointer still 0
    for (int i = 0; i < 8; i++) begin
      add(1, 0, 4'hF, 1, 4'(1 << (i % 4)), 1, 8'hA0 + 8'(i % 4), 2'(i % 4));
    end
    // round-robin sparse
    add(1, 0, 4'b1010, 1, 4'b0010, 1, 8'hA1, 1);
    add(1, 0, 4'b1010, 1, 4'b1000, 1, 8'hA3, 3);
    add(1, 0, 4'b1010, 1, 4'b0010, 1, 8'hA1, 1);
    add(1, 0, 4'b1010, 1, 4'b1000, 1, 8'hA3, 3);
    add(1, 0, 4'b0100, 1, 4'b0100, 1, 8'hA2, 2);
    add(1, 0, 4'b0000, 1, 4'b0000, 0, 8'hA2, 2);
    // fixed grant in between must not move the pointer (still 3)
    add(0, 0, 4'hF, 1, 4'b0001, 1, 8'hA0, 0);
    add(1, 0, 4'hF, 1, 4'b1000, 1, 8'hA3, 3);
    add(1, 0, 4'hF, 1, 4'b0001, 1, 8'hA0, 0);
    add(1, 0, 4'hF, 1, 4'b0010, 1, 8'hA1, 1);
    // backpressure
    add(1, 0, 4'hF, 0, 4'b0000, 1, 8'hA1, 1);
    add(1, 0, 4'hF, 0, 4'b0000, 1, 8'hA1, 1);
    add(1, 0, 4'hF, 0, 4'b0000, 1, 8'hA1, 1);
    add(1, 0, 4'hF, 1, 4'b0100, 1, 8'hA2, 2);

    // reset with all channels valid
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("rst.in_ready", 32'(in_ready), 32'h0);
      chk_out("rst", 1'b0, 8'h00, 2'd0);
    end
    rst = 1'b0;

    foreach (tbl[i]) begin
      mode      = tbl[i].mode;
      sel_n     = tbl[i].sel;
      in_valid  = tbl[i].valid;
      out_ready = tbl[i].oready;
      #1;
      chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
      @(posedge clk);
      #1;
      chk_out($sformatf("vec%0d", i), tbl[i].ov, tbl[i].dat, tbl[i].ch);
    end

    // reset mid-stream with out_valid=1 and pointer at 3
    mode      = 1'b1;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    rst       = 1'b1;
    #1;
    chk("midrst.in_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    chk_out("midrst", 1'b0, 8'h00, 2'd0);
    rst = 1'b0;
    #1;
    chk("post0.in_ready", 32'(in_ready), 32'b0001);
    @(posedge clk);
    #1;
    chk_out("post0", 1'b1, 8'hA0, 2'd0);
    chk("post1.in_ready", 32'(in_ready), 32'b0010);
    @(posedge clk);
    #1;
    chk_out("post1", 1'b1, 8'hA1, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_nto1_rr.md
Name: mux_nto1_rr

Overview:
- Parametrised N:1 channel multiplexer with registered output and valid/ready handshakes on every input channel and on the output.
- Two modes: fixed-select (direct `sel_n`, the successor of the combinational 4:1 mux) and round-robin arbitration across requesting channels.
- Sits between multiple producer streams and one shared downstream consumer.
- Reports which channel won, so the consumer can demultiplex.

Parameters:
- N, 4: number of input channels (2..16).
- W, 8: data width per channel.
- SW, $clog2(N): select / channel-index width (derived localparam, not overridable).

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- data_in, input, N*W: packed channel data; channel k occupies bits [k*W +: W].
- in_valid, input, N: per-channel valid.
- in_ready, output, N: per-channel ready (combinational).
- sel_n, input, SW: channel select, used in fixed mode.
- mode, input, 1: 0 = fixed-select, 1 = round-robin.
- data_out, output, W: registered output data.
- out_ch, output, SW: index of the channel that produced data_out.
- out_valid, output, 1: output valid.
- out_ready, input, 1: downstream ready.

Behaviour:
- Reset (synchronous, checked at posedge clk):
  - out_valid=0, data_out=0, out_ch=0, rr_ptr=0.
  - in_ready=0 while rst is high.
- Load enable: load = !out_valid || out_ready (single-stage pipeline, no bubble under continuous flow).
- Winner selection (combinational each cycle):
  - Fixed mode: winner = sel_n if sel_n < N and in_valid[sel_n]=1; otherwise no winner. sel_n >= N never grants.
  - Round-robin mode: winner = first k with in_valid[k]=1, scanning rr_ptr, rr_ptr+1, ... wrapping modulo N; no winner if in_valid=0.
- Handshake:
  - in_ready[k] = load && (winner==k) && !rst. At most one bit is set.
  - Transfer on a channel occurs when in_valid[k] && in_ready[k].
- On a transfer, at the next posedge:
  - data_out <= channel k data, out_ch <= k, out_valid <= 1.
  - In RR mode only: rr_ptr <= (k+1) mod N.
- Load with no winner: out_valid <= 0; data_out and out_ch hold their previous values.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word per cycle while out_ready=1.
- Backpressure: while out_valid && !out_ready, data_out, out_ch and out_valid stay stable and all in_ready=0.
- Mode switch:
  - Takes effect in the same cycle (selection is combinational).
  - rr_ptr is retained across fixed-mode periods and is not updated by fixed-mode grants.
- Fairness: in RR mode with all N channels continuously valid and out_ready=1, the grant sequence is strictly rr_ptr, +1, ... cyclic; no channel waits more than N-1 grants.
- Reset mid-operation: the pending output word is dropped, out_valid=0 on the next cycle, and arbitration restarts at channel 0.
- Inputs are not required to hold valid, but the bench checks only AXI-style stable sources.

Decomposition:
- Package mux_pkg:
  - MODE_FIXED=1'b0, MODE_RR=1'b1 constants.
  - Channel-index helper function (wrap add modulo N).
- Sub-module rr_arbiter (N parameter):
  - Inputs: req[N-1:0], ptr, enable.
  - Outputs: one-hot grant, grant index, grant_any.
  - Purely combinational.
  - mux_nto1_rr owns rr_ptr, the fixed-mode path and the output register.

Test Plan (N=4, W=8):
- Reset/idle: assert rst 2 cycles with all in_valid=1 -> out_valid=0, data_out=0, out_ch=0, in_ready=0000 throughout reset.
- Fixed select sweep: mode=0, in_valid=1111, data ch0..3 = 8'hA0, A1, A2, A3, out_ready=1, sel_n stepping 0,1,2,3 each cycle.
  - Expect data_out A0, A1, A2, A3 one cycle later each.
  - Expect out_ch 0, 1, 2, 3.
  - Expect in_ready = 0001, 0010, 0100, 1000.
- Fixed select, idle channel: mode=0, sel_n=2, in_valid=1011 -> in_ready=0000; out_valid falls to 0 after the current word drains.
- Round-robin fairness: mode=1, in_valid=1111, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3.
- Round-robin sparse: in_valid=1010 -> out_ch 1,3,1,3; then in_valid=0100 -> out_ch 2.
- Backpressure: after out_ch=1 (data A1) drive out_ready=0 for 3 cycles -> data_out=A1 and out_valid=1 stable, in_ready=0000; on out_ready=1, next word is ch2 (A2) the following cycle.
- Reset mid-stream: assert rst while out_valid=1 and rr_ptr=3 -> out_valid=0 next cycle; after release with in_valid=1111 in RR mode, the first out_ch=0.
